ssp_host_port: RTL and testbench

Synthesizable host-side endpoint of the FPGA-to-ARM SSP link. It consumes the `ssp_clk`/`ssp_frame`/`ssp_din` stream produced by a `hi_*` mode module, deserializes it into bytes, and serializes bytes back onto `ssp_dout`. It is the exact counterpart of the ARM SSP peripheral. It is used as a loopback/host emulator in on-FPGA self-test builds and as the reusable bus-functional endpoint in mode-module benches.

---
 rtl/ssp_pkg.sv | 41 ++++
 rtl/ssp_host_port_if.sv | 28 ++
 rtl/ssp_sync_edge.sv | 65 ++++++
 rtl/ssp_host_port.sv | 180 ++++++++++++++++++
 tb/tb_ssp_host_port.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ssp_pkg.sv
// Shared constants, mode encodings and bit-order helpers for the SSP link.
package ssp_pkg;

  localparam int unsigned SSP_BYTE_BITS   = 8;
  localparam int unsigned SSP_SYNC_STAGES = 2;

  // hi_* mode encodings shared by benches and mode modules.
  typedef enum logic [2:0] {
    SNIFFER       = 3'b000,
    TAGSIM_LISTEN = 3'b001,
    TAGSIM_MOD    = 3'b010,
    READER_LISTEN = 3'b011,
    READER_MOD    = 3'b100,
    TAGSIM_MOD2   = 3'b101
  } ssp_mode_e;

  // Occupancy of the TX holding register.
  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } tx_hold_e;

  // Bit that goes on the wire first for a given byte.
  function automatic logic ssp_first_bit(input logic [SSP_BYTE_BITS-1:0] b,
                                         input bit msb_first);
    return msb_first ? b[SSP_BYTE_BITS-1] : b[0];
  endfunction

  // Advance a TX shifter by one bit so the next wire bit sits in the "first" slot.
  function automatic logic [SSP_BYTE_BITS-1:0] ssp_shift_out(
      input logic [SSP_BYTE_BITS-1:0] b, input bit msb_first);
    return msb_first ? {b[SSP_BYTE_BITS-2:0], 1'b0} : {1'b0, b[SSP_BYTE_BITS-1:1]};
  endfunction

  // Accumulate one received bit; after a full byte the first bit lands per msb_first.
  function automatic logic [SSP_BYTE_BITS-1:0] ssp_shift_in(
      input logic [SSP_BYTE_BITS-1:0] b, input logic bit_in, input bit msb_first);
    return msb_first ? {b[SSP_BYTE_BITS-2:0], bit_in} : {bit_in, b[SSP_BYTE_BITS-1:1]};
  endfunction

endpackage

// File: rtl/ssp_host_port_if.sv
// SSP serial lines plus the host-side RX/TX byte streams of ssp_host_port.
interface ssp_host_port_if;
  import ssp_pkg::*;

  logic                     ssp_clk;
  logic                     ssp_frame;
  logic                     ssp_din;
  logic                     ssp_dout;
  logic [SSP_BYTE_BITS-1:0] rx_data;
  logic                     rx_valid;
  logic                     rx_ready;
  logic [SSP_BYTE_BITS-1:0] tx_data;
  logic                     tx_valid;
  logic                     tx_ready;

  // The host port itself.
  modport master (
    input  ssp_clk, ssp_frame, ssp_din, rx_ready, tx_data, tx_valid,
    output ssp_dout, rx_data, rx_valid, tx_ready
  );

  // Mode module / byte producer-consumer side.
  modport slave (
    output ssp_clk, ssp_frame, ssp_din, rx_ready, tx_data, tx_valid,
    input  ssp_dout, rx_data, rx_valid, tx_ready
  );

endinterface

// File: rtl/ssp_sync_edge.sv
// Multi-flop synchronizers for the asynchronous SSP inputs, plus the
// ssp_clk edge detector producing single-cycle rise/fall strobes.

// Plain synchronizer for ssp_frame / ssp_din.
module ssp_sync2
  import ssp_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SSP_SYNC_STAGES-1:0] sr;

  // Shift the pin value through the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[SSP_SYNC_STAGES-2:0], d};
  end

  assign q = sr[SSP_SYNC_STAGES-1];

endmodule

// Synchronizer with edge strobes, used for ssp_clk.
module ssp_sync_edge
  import ssp_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic                     q;
  logic                     last;
  logic [SSP_SYNC_STAGES:0] primed;
  logic                     armed;

  ssp_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (d),
    .q     (q)
  );

  // Edge-detect register; strobes are held off until both compared samples
  // come from the pin, so a pin already high at reset release is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last   <= 1'b0;
      primed <= '0;
    end else begin
      last   <= q;
      primed <= {primed[SSP_SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign armed = primed[SSP_SYNC_STAGES];
  assign rise  = armed &  q & ~last;
  assign fall  = armed & ~q &  last;

endmodule

// File: rtl/ssp_host_port.sv
// Host-side SSP endpoint: deserializes ssp_din into bytes with a one-deep
// RX output register and serializes a one-deep TX holding register onto
// ssp_dout, with sticky overrun/underrun/frame error flags.
module ssp_host_port
  import ssp_pkg::*;
#(
  parameter bit                       MSB_FIRST = 1'b1,
  parameter logic [SSP_BYTE_BITS-1:0] IDLE_BYTE = 8'h00
) (
  input  logic              ck_1356meg,
  input  logic              rst_n,
  ssp_host_port_if.master   bus,
  output logic [15:0]       byte_count,
  output logic              err_overrun,
  output logic              err_underrun,
  output logic              err_frame,
  input  logic              err_clear
);

  localparam logic [2:0] LAST_BIT = 3'(SSP_BYTE_BITS - 1);

  logic                     rise;
  logic                     fall;
  logic                     frame_s;
  logic                     din_s;

  logic [2:0]               bit_idx;
  logic [2:0]               bit_idx_next;
  logic [SSP_BYTE_BITS-1:0] rx_sh;
  logic                     rx_done;
  logic [SSP_BYTE_BITS-1:0] rx_data_q;
  logic                     rx_valid_q;
  logic                     rx_hs;

  tx_hold_e                 hold_state;
  tx_hold_e                 hold_state_next;
  logic [SSP_BYTE_BITS-1:0] hold;
  logic                     tx_ready_int;
  logic                     tx_hs;
  logic                     tx_load;
  logic [SSP_BYTE_BITS-1:0] tx_src;
  logic [SSP_BYTE_BITS-1:0] tx_sh;
  logic [SSP_BYTE_BITS-1:0] tx_sh_next;
  logic                     dout_q;

  logic                     overrun_evt;
  logic                     underrun_evt;
  logic                     frame_evt;

  ssp_sync_edge u_clk_sync (
    .clk   (ck_1356meg),
    .rst_n (rst_n),
    .d     (bus.ssp_clk),
    .rise  (rise),
    .fall  (fall)
  );

  ssp_sync2 u_frame_sync (
    .clk   (ck_1356meg),
    .rst_n (rst_n),
    .d     (bus.ssp_frame),
    .q     (frame_s)
  );

  ssp_sync2 u_din_sync (
    .clk   (ck_1356meg),
    .rst_n (rst_n),
    .d     (bus.ssp_din),
    .q     (din_s)
  );

  // ---------------------------------------------------------------- RX path
  // Frame realigns to bit 0; without frame the index free-runs 0..7.
  assign bit_idx_next = frame_s ? 3'd0 : bit_idx + 3'd1;
  assign frame_evt    = rise & frame_s & (bit_idx != LAST_BIT);

  // Bit counter and RX shifter, advanced on each ssp_clk rise.
  always_ff @(posedge ck_1356meg or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx <= LAST_BIT;
      rx_sh   <= '0;
      rx_done <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (rise) begin
        bit_idx <= bit_idx_next;
        rx_sh   <= ssp_shift_in(rx_sh, din_s, MSB_FIRST);
        rx_done <= (bit_idx_next == LAST_BIT);
      end
    end
  end

  assign rx_hs       = rx_valid_q & bus.rx_ready;
  assign overrun_evt = rx_done & rx_valid_q & ~rx_hs;

  // RX output register: a completed byte lands only if the slot is free or
  // is being consumed this cycle; otherwise the held byte wins.
  always_ff @(posedge ck_1356meg or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      byte_count <= '0;
    end else if (rx_done) begin
      byte_count <= byte_count + 16'd1;
      if (!rx_valid_q || rx_hs) begin
        rx_data_q  <= rx_sh;
        rx_valid_q <= 1'b1;
      end
    end else if (rx_hs) begin
      rx_valid_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- TX path
  // The fall following the rise that finished a byte starts the next byte;
  // bit_idx resets to 7 so the very first fall after reset also loads.
  assign tx_load      = fall & (bit_idx == LAST_BIT);
  assign tx_ready_int = (hold_state == HOLD_EMPTY);
  assign tx_hs        = bus.tx_valid & tx_ready_int;
  assign tx_src       = (hold_state == HOLD_FULL) ? hold : IDLE_BYTE;
  assign underrun_evt = tx_load & (hold_state == HOLD_EMPTY);
  assign tx_sh_next   = tx_load ? tx_src : ssp_shift_out(tx_sh, MSB_FIRST);

  // Holding register occupancy state.
  always_ff @(posedge ck_1356meg or negedge rst_n) begin
    if (!rst_n) hold_state <= HOLD_EMPTY;
    else        hold_state <= hold_state_next;
  end

  // Fill on handshake, drain on shifter load; a load that reads an empty
  // register may coincide with a fill, leaving it full.
  always_comb begin
    hold_state_next = hold_state;
    case (hold_state)
      HOLD_EMPTY: if (tx_hs)   hold_state_next = HOLD_FULL;
      HOLD_FULL:  if (tx_load) hold_state_next = HOLD_EMPTY;
      default:                 hold_state_next = HOLD_EMPTY;
    endcase
  end

  // Holding register data capture.
  always_ff @(posedge ck_1356meg or negedge rst_n) begin
    if (!rst_n)     hold <= '0;
    else if (tx_hs) hold <= bus.tx_data;
  end

  // TX shifter and output bit, both advanced on each ssp_clk fall.
  always_ff @(posedge ck_1356meg or negedge rst_n) begin
    if (!rst_n) begin
      tx_sh  <= IDLE_BYTE;
      dout_q <= 1'b0;
    end else if (fall) begin
      tx_sh  <= tx_sh_next;
      dout_q <= ssp_first_bit(tx_sh_next, MSB_FIRST);
    end
  end

  // ------------------------------------------------------------ error flags
  // Sticky flags; a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge ck_1356meg or negedge rst_n) begin
    if (!rst_n) begin
      err_overrun  <= 1'b0;
      err_underrun <= 1'b0;
      err_frame    <= 1'b0;
    end else begin
      if (overrun_evt)    err_overrun  <= 1'b1;
      else if (err_clear) err_overrun  <= 1'b0;
      if (underrun_evt)   err_underrun <= 1'b1;
      else if (err_clear) err_underrun <= 1'b0;
      if (frame_evt)      err_frame    <= 1'b1;
      else if (err_clear) err_frame    <= 1'b0;
    end
  end

  assign bus.ssp_dout = dout_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.tx_ready = tx_ready_int;

endmodule

// File: tb/tb_ssp_host_port.sv
// Self-checking bench for ssp_host_port: an MSB-first instance (IDLE 8'hC3)
// and an LSB-first instance (IDLE 8'h00) driven by one shared SSP stream.
module tb_ssp_host_port;

  logic ck = 1'b0;
  always #5 ck = ~ck;

  logic       rst_n;
  logic       ssp_clk, ssp_frame, ssp_din;
  logic       rx_ready, tx_valid, err_clear;
  logic [7:0] tx_data;

  ssp_host_port_if bus_m ();
  ssp_host_port_if bus_l ();

  assign bus_m.ssp_clk   = ssp_clk;
  assign bus_m.ssp_frame = ssp_frame;
  assign bus_m.ssp_din   = ssp_din;
  assign bus_m.rx_ready  = rx_ready;
  assign bus_m.tx_data   = tx_data;
  assign bus_m.tx_valid  = tx_valid;
  assign bus_l.ssp_clk   = ssp_clk;
  assign bus_l.ssp_frame = ssp_frame;
  assign bus_l.ssp_din   = ssp_din;
  assign bus_l.rx_ready  = rx_ready;
  assign bus_l.tx_data   = tx_data;
  assign bus_l.tx_valid  = tx_valid;

  logic [15:0] cnt_m, cnt_l;
  logic        ovr_m, und_m, frm_m, ovr_l, und_l, frm_l;

  ssp_host_port #(.MSB_FIRST(1'b1), .IDLE_BYTE(8'hC3)) u_msb (
    .ck_1356meg   (ck),
    .rst_n        (rst_n),
    .bus          (bus_m),
    .byte_count   (cnt_m),
    .err_overrun  (ovr_m),
    .err_underrun (und_m),
    .err_frame    (frm_m),
    .err_clear    (err_clear)
  );

  ssp_host_port #(.MSB_FIRST(1'b0), .IDLE_BYTE(8'h00)) u_lsb (
    .ck_1356meg   (ck),
    .rst_n        (rst_n),
    .bus          (bus_l),
    .byte_count   (cnt_l),
    .err_overrun  (ovr_l),
    .err_underrun (und_l),
    .err_frame    (frm_l),
    .err_clear    (err_clear)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // One ssp_clk period as a mode module would drive it: fall, sample the
  // host's dout late in the low half, present frame/din, then rise.
  task automatic send_bit(input logic f, input logic d, input logic loop,
                          input logic clr_at_load, output logic dm, output logic dl);
    ssp_clk = 1'b0;
    repeat (2) @(negedge ck);
    if (clr_at_load) err_clear = 1'b1;   // lands on the cycle the fall strobe acts
    @(negedge ck);
    err_clear = 1'b0;
    repeat (3) @(negedge ck);
    dm = bus_m.ssp_dout;
    dl = bus_l.ssp_dout;
    ssp_frame = f;
    ssp_din   = loop ? dm : d;
    repeat (2) @(negedge ck);
    ssp_clk = 1'b1;
    repeat (8) @(negedge ck);
  endtask

  // b is in wire order: b[7] is sent first. Captured dout bytes use the same order.
  task automatic send_byte(input logic [7:0] b, input logic framed, input logic loop,
                           input logic clr, output logic [7:0] cm, output logic [7:0] cl);
    logic dm, dl;
    for (int j = 0; j < 8; j++) begin
      send_bit(framed && (j == 0), b[7-j], loop, clr && (j == 0), dm, dl);
      cm[7-j] = dm;
      cl[7-j] = dl;
    end
  endtask

  task automatic pulse_rx_ready();
    rx_ready = 1'b1;
    @(negedge ck);
    rx_ready = 1'b0;
  endtask

  task automatic offer_tx(input logic [7:0] v);
    tx_data  = v;
    tx_valid = 1'b1;
    @(negedge ck);
    tx_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    @(negedge ck);
    err_clear = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge ck);
    rst_n = 1'b1;
    repeat (4) @(negedge ck);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_dout_m"},  {15'd0, bus_m.ssp_dout}, 16'd0);
    chk({tag, "_dout_l"},  {15'd0, bus_l.ssp_dout}, 16'd0);
    chk({tag, "_rxd_m"},   {8'd0, bus_m.rx_data},   16'd0);
    chk({tag, "_rxv_m"},   {15'd0, bus_m.rx_valid}, 16'd0);
    chk({tag, "_rxv_l"},   {15'd0, bus_l.rx_valid}, 16'd0);
    chk({tag, "_txr_m"},   {15'd0, bus_m.tx_ready}, 16'd1);
    chk({tag, "_cnt_m"},   cnt_m,                   16'd0);
    chk({tag, "_cnt_l"},   cnt_l,                   16'd0);
    chk({tag, "_errs_m"},  {13'd0, ovr_m, und_m, frm_m}, 16'd0);
    chk({tag, "_errs_l"},  {13'd0, ovr_l, und_l, frm_l}, 16'd0);
  endtask

  typedef struct {
    logic [7:0] bits;  // wire order, first bit = bits[7]
    logic [7:0] tx;    // byte offered to both instances
    logic [7:0] rx_m;  // expected rx_data, MSB-first instance
    logic [7:0] rx_l;  // expected rx_data, LSB-first instance
    logic [7:0] cap_m; // expected dout capture (wire order), MSB-first
    logic [7:0] cap_l; // expected dout capture (wire order), LSB-first
  } vec_t;

  vec_t vecs [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, %0d checks, %0d errors", n_chk, n_err);
    $fatal(1);
  end

  initial begin
    logic [7:0] cm, cl, b, t, exp_m, exp_l, md;
    logic       mv, movr, mund, offered;
    int         mcount;

    vecs[0] = '{8'h80, 8'h01, 8'h80, 8'h01, 8'h01, 8'h80};
    vecs[1] = '{8'h01, 8'h10, 8'h01, 8'h80, 8'h10, 8'h08};
    vecs[2] = '{8'hA5, 8'h3C, 8'hA5, 8'hA5, 8'h3C, 8'h3C};
    vecs[3] = '{8'hF0, 8'hE1, 8'hF0, 8'h0F, 8'hE1, 8'h87};
    vecs[4] = '{8'h96, 8'h5A, 8'h96, 8'h69, 8'h5A, 8'h5A};
    vecs[5] = '{8'hC8, 8'h02, 8'hC8, 8'h13, 8'h02, 8'h40};

    rst_n = 1'b0; ssp_clk = 1'b1; ssp_frame = 1'b0; ssp_din = 1'b0;
    rx_ready = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; err_clear = 1'b0;
    repeat (3) @(negedge ck);
    check_reset_vals("rst_in");
    rst_n = 1'b1;
    repeat (4) @(negedge ck);
    check_reset_vals("rst_out");

    // Table: per byte, TX offered ahead of the byte and RX consumed after.
    for (int i = 0; i < 6; i++) begin
      offer_tx(vecs[i].tx);
      send_byte(vecs[i].bits, 1'b1, 1'b0, 1'b0, cm, cl);
      chk($sformatf("tab%0d_rxv_m", i), {15'd0, bus_m.rx_valid}, 16'd1);
      chk($sformatf("tab%0d_rxd_m", i), {8'd0, bus_m.rx_data}, {8'd0, vecs[i].rx_m});
      chk($sformatf("tab%0d_rxd_l", i), {8'd0, bus_l.rx_data}, {8'd0, vecs[i].rx_l});
      chk($sformatf("tab%0d_tx_m", i),  {8'd0, cm}, {8'd0, vecs[i].cap_m});
      chk($sformatf("tab%0d_tx_l", i),  {8'd0, cl}, {8'd0, vecs[i].cap_l});
      pulse_rx_ready();
      @(negedge ck);
      chk($sformatf("tab%0d_rxv_drop", i), {15'd0, bus_m.rx_valid}, 16'd0);
    end
    chk("tab_cnt_m", cnt_m, 16'd6);
    chk("tab_cnt_l", cnt_l, 16'd6);
    chk("tab_errs_m", {13'd0, ovr_m, und_m, frm_m}, 16'd0);

    // Loopback: din echoes the MSB-first instance's dout bit for bit.
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      offer_tx(8'(k));
      send_byte(8'h00, 1'b1, 1'b1, 1'b0, cm, cl);
      chk($sformatf("lb%0d_rxd", k), {8'd0, bus_m.rx_data}, 16'(k));
      chk($sformatf("lb%0d_rxv", k), {15'd0, bus_m.rx_valid}, 16'd1);
      pulse_rx_ready();
    end
    chk("lb_cnt", cnt_m, 16'd16);
    chk("lb_errs", {13'd0, ovr_m, und_m, frm_m}, 16'd0);

    // Underrun: nothing offered, the idle byte goes out three times.
    for (int k = 0; k < 3; k++) begin
      send_byte(8'h5C, 1'b1, 1'b0, 1'b0, cm, cl);
      chk($sformatf("und%0d_tx_m", k), {8'd0, cm}, 16'h00C3);
      chk($sformatf("und%0d_tx_l", k), {8'd0, cl}, 16'h0000);
      pulse_rx_ready();
    end
    chk("und_flag_m", {15'd0, und_m}, 16'd1);
    chk("und_flag_l", {15'd0, und_l}, 16'd1);
    pulse_clear();
    chk("und_cleared", {15'd0, und_m}, 16'd0);
    send_byte(8'h5C, 1'b1, 1'b0, 1'b1, cm, cl);
    chk("und_clr_same_cycle", {15'd0, und_m}, 16'd1);
    chk("und_clr_tx_m", {8'd0, cm}, 16'h00C3);
    pulse_rx_ready();

    // Overrun: two bytes with no consumer.
    do_reset();
    send_byte(8'hA5, 1'b1, 1'b0, 1'b0, cm, cl);
    chk("ovr_first_clean", {15'd0, ovr_m}, 16'd0);
    send_byte(8'h5A, 1'b1, 1'b0, 1'b0, cm, cl);
    chk("ovr_rxd_m", {8'd0, bus_m.rx_data}, 16'h00A5);
    chk("ovr_rxd_l", {8'd0, bus_l.rx_data}, 16'h00A5);
    chk("ovr_rxv", {15'd0, bus_m.rx_valid}, 16'd1);
    chk("ovr_flag", {15'd0, ovr_m}, 16'd1);
    chk("ovr_cnt", cnt_m, 16'd2);

    // Frame error: frame re-asserted at bit 4 of a byte.
    pulse_rx_ready();
    pulse_clear();
    for (int j = 0; j < 4; j++) send_bit(j == 0, 1'b1, 1'b0, 1'b0, cm[0], cl[0]);
    chk("frm_partial_rxv", {15'd0, bus_m.rx_valid}, 16'd0);
    chk("frm_partial_cnt", cnt_m, 16'd2);
    send_byte(8'h1E, 1'b1, 1'b0, 1'b0, cm, cl);
    chk("frm_flag_m", {15'd0, frm_m}, 16'd1);
    chk("frm_flag_l", {15'd0, frm_l}, 16'd1);
    chk("frm_cnt", cnt_m, 16'd3);
    chk("frm_rxd_m", {8'd0, bus_m.rx_data}, 16'h001E);
    chk("frm_rxd_l", {8'd0, bus_l.rx_data}, 16'h0078);

    // Missing frame: alignment free-runs, no frame error.
    pulse_rx_ready();
    pulse_clear();
    send_byte(8'h6B, 1'b0, 1'b0, 1'b0, cm, cl);
    chk("nofrm_rxd_m", {8'd0, bus_m.rx_data}, 16'h006B);
    chk("nofrm_rxd_l", {8'd0, bus_l.rx_data}, 16'h00D6);
    chk("nofrm_cnt", cnt_m, 16'd4);
    chk("nofrm_flag", {15'd0, frm_m}, 16'd0);

    // Reset pulse mid-byte: outputs return at once, next byte arrives intact.
    for (int j = 0; j < 3; j++) send_bit(j == 0, 1'b1, 1'b0, 1'b0, cm[0], cl[0]);
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    @(negedge ck);
    @(negedge ck);
    rst_n = 1'b1;
    ssp_frame = 1'b0;
    repeat (4) @(negedge ck);
    send_byte(8'h8C, 1'b1, 1'b0, 1'b0, cm, cl);
    chk("rst_mid_rxd_m", {8'd0, bus_m.rx_data}, 16'h008C);
    chk("rst_mid_rxd_l", {8'd0, bus_l.rx_data}, 16'h0031);
    chk("rst_mid_cnt", cnt_m, 16'd1);
    chk("rst_mid_frm", {15'd0, frm_m}, 16'd0);

    // Random traffic against a byte-level model of both instances.
    do_reset();
    mv = 1'b0; md = 8'h00; movr = 1'b0; mund = 1'b0; mcount = 0;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        pulse_clear();
        movr = 1'b0;
        mund = 1'b0;
      end
      if ($urandom_range(0, 1) == 1) begin
        if (mv) begin
          chk($sformatf("rnd%0d_rxd_m", n), {8'd0, bus_m.rx_data}, {8'd0, md});
          chk($sformatf("rnd%0d_rxd_l", n), {8'd0, bus_l.rx_data}, {8'd0, rev8(md)});
        end
        pulse_rx_ready();
        mv = 1'b0;
      end
      offered = ($urandom_range(0, 3) != 0);
      t = 8'($urandom);
      if (offered) begin
        chk($sformatf("rnd%0d_txr", n), {15'd0, bus_m.tx_ready}, 16'd1);
        offer_tx(t);
      end
      b = 8'($urandom);
      send_byte(b, 1'b1, 1'b0, 1'b0, cm, cl);
      exp_m = offered ? t : 8'hC3;
      exp_l = offered ? t : 8'h00;
      if (!offered) mund = 1'b1;
      mcount++;
      if (mv) movr = 1'b1;
      else begin
        mv = 1'b1;
        md = b;
      end
      chk($sformatf("rnd%0d_tx_m", n), {8'd0, cm}, {8'd0, exp_m});
      chk($sformatf("rnd%0d_tx_l", n), {8'd0, cl}, {8'd0, rev8(exp_l)});
      chk($sformatf("rnd%0d_rxv", n), {15'd0, bus_m.rx_valid}, {15'd0, mv});
      chk($sformatf("rnd%0d_cnt", n), cnt_m, 16'(mcount));
      chk($sformatf("rnd%0d_ovr", n), {15'd0, ovr_m}, {15'd0, movr});
      chk($sformatf("rnd%0d_und_m", n), {15'd0, und_m}, {15'd0, mund});
      chk($sformatf("rnd%0d_und_l", n), {15'd0, und_l}, {15'd0, mund});
      chk($sformatf("rnd%0d_txr_after", n), {15'd0, bus_l.tx_ready}, 16'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
